// File: rtl/mmapadd_job_sched_pkg.sv
// Shared types for the mMapAdd job scheduler: accelerator word/pointer types,
// scheduler state encoding and the stream-source selector.
package mmapadd_job_sched_pkg;

    localparam int QTREE_BOOL_W = 67;
    localparam int POINTER_W    = 32;

    typedef logic [QTREE_BOOL_W-1:0] QTree_Bool_t;
    typedef logic [POINTER_W-1:0]    Pointer_QTree_Nat_t;

    // Bit of the result pointer that marks it as valid.
    localparam int RESULT_VALID_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED0,
        S_FEED1,
        S_WAIT_RES,
        S_DONE,
        S_ERR
    } sched_state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_0,
        SRC_1
    } src_sel_t;

endpackage

// File: rtl/mmapadd_job_sched_stream_mux.sv
// 2:1 combinational stream selector feeding the accelerator input. The
// selected source passes straight through; tlast is generated from the
// current word count against that source's latched length.
module mmapadd_stream_mux
    import mmapadd_job_sched_pkg::*;
#(
    parameter int DATA_W = 67,
    parameter int LEN_W  = 16
) (
    input  src_sel_t          sel,
    input  logic [LEN_W-1:0]  cnt,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              beat
);

    // Route the selected source to the output; idle outputs are all zero.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        m_tdata   = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (sel)
            SRC_0: begin
                m_tdata   = s0_tdata;
                m_tvalid  = s0_tvalid;
                m_tlast   = (cnt == len0 - LEN_W'(1));
                s0_tready = m_tready;
            end
            SRC_1: begin
                m_tdata   = s1_tdata;
                m_tvalid  = s1_tvalid;
                m_tlast   = (cnt == len1 - LEN_W'(1));
                s1_tready = m_tready;
            end
            default: ;
        endcase
    end

    assign beat = m_tvalid & m_tready;

endmodule

// File: rtl/mmapadd_job_sched.sv
// Job controller for mMapAdd_wrapper: feeds operand tree 0 then tree 1 onto
// the accelerator input, waits for the result pointer and reports done, or
// reports error on a zero length or a result timeout.
module mmapadd_job_sched
    import mmapadd_job_sched_pkg::*;
#(
    parameter int DATA_W  = 67,
    parameter int PTR_W   = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              job_start,
    input  logic [LEN_W-1:0]  job_len0,
    input  logic [LEN_W-1:0]  job_len1,
    input  logic              job_abort,
    output logic              job_busy,
    output logic              job_done,
    output logic              job_error,
    output logic [PTR_W-1:0]  job_result,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    input  logic [PTR_W-1:0]  res_tdata,
    output logic              res_tready
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    sched_state_t     state;
    src_sel_t         sel;
    logic [LEN_W-1:0] len0_q;
    logic [LEN_W-1:0] len1_q;
    logic [LEN_W-1:0] cnt;
    logic [TMR_W-1:0] timer;
    logic             beat;

    // Pick the stream source from the current feed state.
    always_comb begin
        sel = SRC_NONE;
        case (state)
            S_FEED0: sel = SRC_0;
            S_FEED1: sel = SRC_1;
            default: sel = SRC_NONE;
        endcase
    end

    mmapadd_stream_mux #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_mux (
        .sel       (sel),
        .cnt       (cnt),
        .len0      (len0_q),
        .len1      (len1_q),
        .s0_tdata  (s0_tdata),
        .s0_tvalid (s0_tvalid),
        .s0_tready (s0_tready),
        .s1_tdata  (s1_tdata),
        .s1_tvalid (s1_tvalid),
        .s1_tready (s1_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .beat      (beat)
    );

    // Scheduler FSM with word counter, result timer and registered status outputs.
    always_ff @(posedge aclk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // sees the pre-edge values of the others.
        if (areset) begin
            state      <= S_IDLE;
            len0_q     <= '0;
            len1_q     <= '0;
            cnt        <= '0;
            timer      <= '0;
            job_result <= '0;
            job_busy   <= 1'b0;
            job_done   <= 1'b0;
            job_error  <= 1'b0;
            res_tready <= 1'b0;
        end else begin
            job_done  <= 1'b0;
            job_error <= 1'b0;
            if (state != S_IDLE && job_abort) begin
                // Abort wins over everything; a beat this cycle already transferred.
                state      <= S_IDLE;
                cnt        <= '0;
                timer      <= '0;
                job_busy   <= 1'b0;
                res_tready <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (job_start) begin
                            len0_q     <= job_len0;
                            len1_q     <= job_len1;
                            cnt        <= '0;
                            job_result <= '0;
                            job_busy   <= 1'b1;
                            if (job_len0 == '0 || job_len1 == '0) begin
                                state     <= S_ERR;
                                job_error <= 1'b1;
                            end else begin
                                state <= S_FEED0;
                            end
                        end
                    end
                    S_FEED0: begin
                        if (beat) begin
                            if (m_tlast) begin
                                cnt   <= '0;
                                state <= S_FEED1;
                            end else begin
                                cnt <= cnt + LEN_W'(1);
                            end
                        end
                    end
                    S_FEED1: begin
                        if (beat) begin
                            if (m_tlast) begin
                                cnt        <= '0;
                                timer      <= '0;
                                state      <= S_WAIT_RES;
                                res_tready <= 1'b1;
                            end else begin
                                cnt <= cnt + LEN_W'(1);
                            end
                        end
                    end
                    S_WAIT_RES: begin
                        // A result on the timeout cycle still counts as a result.
                        if (res_tdata[RESULT_VALID_BIT]) begin
                            job_result <= res_tdata;
                            state      <= S_DONE;
                            job_done   <= 1'b1;
                            res_tready <= 1'b0;
                        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                            timer      <= '0;
                            state      <= S_ERR;
                            job_error  <= 1'b1;
                            res_tready <= 1'b0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    S_DONE, S_ERR: begin
                        state    <= S_IDLE;
                        job_busy <= 1'b0;
                    end
                    default: begin
                        state      <= S_IDLE;
                        job_busy   <= 1'b0;
                        res_tready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmapadd_job_sched.sv
// Self-checking bench for mmapadd_job_sched: scoreboard of expected stream
// beats and result pointers, one task per scenario.
module tb_mmapadd_job_sched;

    localparam int DATA_W  = 67;
    localparam int PTR_W   = 32;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 16;

    logic              aclk = 1'b0;
    logic              areset;
    logic              job_start;
    logic [LEN_W-1:0]  job_len0;
    logic [LEN_W-1:0]  job_len1;
    logic              job_abort;
    logic              job_busy;
    logic              job_done;
    logic              job_error;
    logic [PTR_W-1:0]  job_result;
    logic [DATA_W-1:0] s0_tdata;
    logic              s0_tvalid;
    logic              s0_tready;
    logic [DATA_W-1:0] s1_tdata;
    logic              s1_tvalid;
    logic              s1_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [PTR_W-1:0]  res_tdata;
    logic              res_tready;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              src;
    } beat_t;

    beat_t            exp_q[$];
    logic [PTR_W-1:0] res_q[$];
    int               errors = 0;
    int               checks = 0;
    int               idx0;
    int               idx1;

    always #5 aclk = ~aclk;

    mmapadd_job_sched #(
        .DATA_W  (DATA_W),
        .PTR_W   (PTR_W),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .job_start  (job_start),
        .job_len0   (job_len0),
        .job_len1   (job_len1),
        .job_abort  (job_abort),
        .job_busy   (job_busy),
        .job_done   (job_done),
        .job_error  (job_error),
        .job_result (job_result),
        .s0_tdata   (s0_tdata),
        .s0_tvalid  (s0_tvalid),
        .s0_tready  (s0_tready),
        .s1_tdata   (s1_tdata),
        .s1_tvalid  (s1_tvalid),
        .s1_tready  (s1_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .res_tdata  (res_tdata),
        .res_tready (res_tready)
    );

    // Distinct word per source and index so reordering or duplication shows up.
    function automatic logic [DATA_W-1:0] word(input bit src, input int i);
        logic [31:0] lo;
        logic [31:0] mid;
        lo  = 32'hFACE_0000 + 32'(i);
        mid = src ? 32'h1111_0000 + 32'(i) : 32'h2222_0000 + 32'(i);
        return {src ? 3'b101 : 3'b010, mid, lo};
    endfunction

    // Start a job, then act as both sources and the sink until max_beats
    // beats went out or the scoreboard is empty.
    task automatic run_feed(input int l0, input int l1, input bit toggle,
                            input int max_beats, input bit collide);
        beat_t b;
        int    n     = 0;
        int    beats = 0;
        int    want;
        bit    ph    = 1'b1;
        bit    adv0;
        bit    adv1;
        idx0 = 0;
        idx1 = 0;
        exp_q.delete();
        for (int i = 0; i < l0; i++) begin
            b.data = word(1'b0, i); b.last = (i == l0 - 1); b.src = 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < l1; i++) begin
            b.data = word(1'b1, i); b.last = (i == l1 - 1); b.src = 1'b1;
            exp_q.push_back(b);
        end
        want = (max_beats < l0 + l1) ? max_beats : l0 + l1;
        job_start = 1'b1;
        job_len0  = LEN_W'(l0);
        job_len1  = LEN_W'(l1);
        @(posedge aclk); #1;
        job_start = 1'b0;
        while (exp_q.size() != 0 && beats < max_beats && n < 200) begin
            m_tready  = toggle ? ph : 1'b1;
            ph        = ~ph;
            s0_tvalid = 1'b1;
            s1_tvalid = 1'b1;
            s0_tdata  = word(1'b0, idx0);
            s1_tdata  = word(1'b1, idx1);
            if (collide && n == 1) begin
                job_start = 1'b1;
                job_len0  = 1;
                job_len1  = 1;
            end else begin
                job_start = 1'b0;
            end
            @(negedge aclk);
            checks++;
            if (m_tvalid !== 1'b1 || s0_tready !== (m_tready & ~exp_q[0].src)
                || s1_tready !== (m_tready & exp_q[0].src)) begin
                errors++;
                $display("FAIL feed_handshake cycle %0d: m_tvalid=%b s0_tready=%b s1_tready=%b, expected 1 %b %b",
                         n, m_tvalid, s0_tready, s1_tready,
                         m_tready & ~exp_q[0].src, m_tready & exp_q[0].src);
            end
            adv0 = s0_tvalid & (s0_tready === 1'b1);
            adv1 = s1_tvalid & (s1_tready === 1'b1);
            if (m_tvalid === 1'b1 && m_tready) begin
                b = exp_q.pop_front();
                beats++;
                checks++;
                if (m_tdata !== b.data || m_tlast !== b.last) begin
                    errors++;
                    $display("FAIL feed_beat %0d: data=%h last=%b, expected data=%h last=%b",
                             beats, m_tdata, m_tlast, b.data, b.last);
                end
            end
            @(posedge aclk); #1;
            if (adv0) idx0++;
            if (adv1) idx1++;
            n++;
        end
        job_start = 1'b0;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        m_tready  = 1'b1;
        checks++;
        if (beats != want) begin
            errors++;
            $display("FAIL feed_beat_count: got %0d beats, expected %0d", beats, want);
        end
    endtask

    // From the first WAIT_RES cycle: one idle cycle, then deliver ptr.
    task automatic get_result(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] e;
        res_tdata = '0;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        m_tready  = 1'b1;
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0 || s0_tready !== 1'b0 || s1_tready !== 1'b0
            || res_tready !== 1'b1 || job_busy !== 1'b1 || job_done !== 1'b0) begin
            errors++;
            $display("FAIL wait_res_state: m_tvalid=%b s0_tready=%b s1_tready=%b res_tready=%b busy=%b done=%b, expected 0 0 0 1 1 0",
                     m_tvalid, s0_tready, s1_tready, res_tready, job_busy, job_done);
        end
        @(posedge aclk); #1;
        res_tdata = ptr;
        res_q.push_back(ptr);
        @(posedge aclk); #1;
        res_tdata = '0;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        @(negedge aclk);
        e = res_q.pop_front();
        checks++;
        if (job_done !== 1'b1 || job_error !== 1'b0 || job_result !== e || res_tready !== 1'b0) begin
            errors++;
            $display("FAIL result_capture: done=%b error=%b result=%h res_tready=%b, expected 1 0 %h 0",
                     job_done, job_error, job_result, res_tready, e);
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++;
        if (job_done !== 1'b0 || job_busy !== 1'b0 || job_result !== e) begin
            errors++;
            $display("FAIL result_after_done: done=%b busy=%b result=%h, expected 0 0 %h",
                     job_done, job_busy, job_result, e);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        job_start = 1'b0;
        job_len0  = '0;
        job_len1  = '0;
        job_abort = 1'b0;
        s0_tdata  = '0;
        s0_tvalid = 1'b0;
        s1_tdata  = '0;
        s1_tvalid = 1'b0;
        m_tready  = 1'b0;
        res_tdata = '0;
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++;
        if ({job_busy, job_done, job_error, res_tready, m_tvalid, m_tlast, s0_tready, s1_tready} !== 8'h00
            || job_result !== '0 || m_tdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b error=%b res_tready=%b m_tvalid=%b result=%h, expected all 0",
                     job_busy, job_done, job_error, res_tready, m_tvalid, job_result);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic test_nominal();
        run_feed(3, 2, 1'b0, 100, 1'b0);
        get_result(32'h0000_0041);
    endtask

    task automatic test_backpressure();
        run_feed(4, 4, 1'b1, 100, 1'b0);
        get_result(32'h1234_5679);
    endtask

    task automatic test_zero_length();
        for (int p = 0; p < 2; p++) begin
            job_start = 1'b1;
            job_len0  = (p == 0) ? 16'd0 : 16'd5;
            job_len1  = (p == 0) ? 16'd5 : 16'd0;
            s0_tvalid = 1'b1;
            s1_tvalid = 1'b1;
            m_tready  = 1'b1;
            @(posedge aclk); #1;
            job_start = 1'b0;
            @(negedge aclk);
            checks++;
            if (job_error !== 1'b1 || job_busy !== 1'b1 || m_tvalid !== 1'b0 || job_done !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_err p=%0d: error=%b busy=%b m_tvalid=%b done=%b, expected 1 1 0 0",
                         p, job_error, job_busy, m_tvalid, job_done);
            end
            @(posedge aclk); #1;
            @(negedge aclk);
            checks++;
            if (job_error !== 1'b0 || job_busy !== 1'b0 || m_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_idle p=%0d: error=%b busy=%b m_tvalid=%b, expected 0 0 0",
                         p, job_error, job_busy, m_tvalid);
            end
            s0_tvalid = 1'b0;
            s1_tvalid = 1'b0;
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [PTR_W-1:0] e;
        run_feed(1, 1, 1'b0, 100, 1'b0);
        res_tdata = '0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge aclk);
            checks++;
            if (job_error !== 1'b0 || job_done !== 1'b0 || res_tready !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait k=%0d: error=%b done=%b res_tready=%b, expected 0 0 1",
                         k, job_error, job_done, res_tready);
            end
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        checks++;
        if (job_error !== 1'b1 || job_done !== 1'b0 || job_result !== '0 || res_tready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error: error=%b done=%b result=%h res_tready=%b, expected 1 0 0 0",
                     job_error, job_done, job_result, res_tready);
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++;
        if (job_error !== 1'b0 || job_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: error=%b busy=%b, expected 0 0", job_error, job_busy);
        end
        @(posedge aclk); #1;
        // Result arriving on the last allowed cycle wins over the timeout.
        run_feed(1, 1, 1'b0, 100, 1'b0);
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            @(posedge aclk); #1;
        end
        res_tdata = 32'hDEAD_BEE1;
        res_q.push_back(32'hDEAD_BEE1);
        @(posedge aclk); #1;
        res_tdata = '0;
        @(negedge aclk);
        e = res_q.pop_front();
        checks++;
        if (job_done !== 1'b1 || job_error !== 1'b0 || job_result !== e) begin
            errors++;
            $display("FAIL timeout_edge_result: done=%b error=%b result=%h, expected 1 0 %h",
                     job_done, job_error, job_result, e);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_abort();
        run_feed(2, 3, 1'b0, 3, 1'b0);
        // Now in FEED1 after one source-1 beat; abort with a beat in flight.
        job_abort = 1'b1;
        m_tready  = 1'b1;
        s1_tvalid = 1'b1;
        s1_tdata  = word(1'b1, 1);
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b1 || s1_tready !== 1'b1 || m_tdata !== word(1'b1, 1) || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL abort_beat: m_tvalid=%b s1_tready=%b m_tlast=%b data=%h, expected 1 1 0 %h",
                     m_tvalid, s1_tready, m_tlast, m_tdata, word(1'b1, 1));
        end
        @(posedge aclk); #1;
        job_abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            checks++;
            if (job_busy !== 1'b0 || job_done !== 1'b0 || job_error !== 1'b0
                || m_tvalid !== 1'b0 || s1_tready !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle k=%0d: busy=%b done=%b error=%b m_tvalid=%b s1_tready=%b, expected all 0",
                         k, job_busy, job_done, job_error, m_tvalid, s1_tready);
            end
            @(posedge aclk); #1;
        end
        s1_tvalid = 1'b0;
        exp_q.delete();
        run_feed(1, 1, 1'b0, 100, 1'b0);
        get_result(32'h0000_0105);
    endtask

    task automatic test_collision_and_reset();
        // A second job_start during FEED0 must not disturb the 3+2 job.
        run_feed(3, 2, 1'b0, 100, 1'b1);
        res_tdata = '0;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        m_tready  = 1'b1;
        @(negedge aclk);
        checks++;
        if (res_tready !== 1'b1 || job_busy !== 1'b1) begin
            errors++;
            $display("FAIL collide_wait: res_tready=%b busy=%b, expected 1 1", res_tready, job_busy);
        end
        areset = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++;
        if ({job_busy, job_done, job_error, res_tready, m_tvalid, m_tlast, s0_tready, s1_tready} !== 8'h00
            || job_result !== '0 || m_tdata !== '0) begin
            errors++;
            $display("FAIL reset_in_wait: busy=%b done=%b error=%b res_tready=%b m_tvalid=%b s0_tready=%b result=%h, expected all 0",
                     job_busy, job_done, job_error, res_tready, m_tvalid, s0_tready, job_result);
        end
        @(posedge aclk); #1;
        areset    = 1'b0;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_zero_length();
        test_timeout();
        test_abort();
        test_collision_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmapadd_job_sched.md
Name: mmapadd_job_sched

Overview:
Job controller in front of mMapAdd_wrapper. It takes one job request carrying two operand-tree lengths and sequences the two operand streams, source 0 then source 1, onto the accelerator's single input stream, asserting tlast on the last word of each tree. It then waits for the result pointer, captures it, and reports done, or reports error on a bad length or a timeout. It replaces the hand-sequenced stimulus logic used around the accelerator today.

Parameters:
DATA_W, 67, width of one QTree_Bool_t stream word
PTR_W, 32, width of Pointer_QTree_Nat_t; bit 0 is the result-valid flag
LEN_W, 16, width of the operand word counters
TIMEOUT, 65535, maximum cycles spent in WAIT_RES before error

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
job_start  in  1  one-cycle request; accepted only in IDLE
job_len0  in  LEN_W  word count of operand tree 0; sampled on accept
job_len1  in  LEN_W  word count of operand tree 1; sampled on accept
job_abort  in  1  abandon the current job and return to IDLE
job_busy  out  1  high in any state other than IDLE
job_done  out  1  one-cycle pulse when the result is captured
job_error  out  1  one-cycle pulse on a zero length or a timeout
job_result  out  PTR_W  captured result pointer; held until the next accept
s0_tdata  in  DATA_W  operand 0 stream data
s0_tvalid  in  1  operand 0 stream valid
s0_tready  out  1  operand 0 stream ready
s1_tdata  in  DATA_W  operand 1 stream data
s1_tvalid  in  1  operand 1 stream valid
s1_tready  out  1  operand 1 stream ready
m_tdata  out  DATA_W  to the accelerator i_tdata
m_tvalid  out  1  to the accelerator i_tvalid
m_tlast  out  1  to the accelerator i_tlast
m_tready  in  1  from the accelerator i_tready
res_tdata  in  PTR_W  from the accelerator o_tdata
res_tready  out  1  to the accelerator o_tready

Behaviour:
- Reset (areset=1 at a rising edge of aclk): state is IDLE, counters are 0, job_result is 0. Every output is 0 except res_tready, which is 0 outside WAIT_RES.
- States: IDLE, FEED0, FEED1, WAIT_RES, DONE, ERR.
- IDLE, job_start=1: latch len0 and len1, clear job_result and cnt.
  - Either length 0 -> ERR.
  - Otherwise -> FEED0.
- FEED0: combinational pass-through, no added latency.
  - m_tdata=s0_tdata, m_tvalid=s0_tvalid, s0_tready=m_tready; s1_tready=0.
  - m_tlast=(cnt==len0-1).
  - A beat is s0_tvalid & m_tready. Each beat increments cnt.
  - Beat with tlast: cnt<=0, go to FEED1.
- FEED1: identical to FEED0 with source 1 and len1, s0_tready=0. Beat with tlast -> WAIT_RES, timer<=0.
- Outside the FEED states: m_tvalid=0, m_tlast=0, m_tdata=0, and both s*_tready=0.
- WAIT_RES: res_tready=1.
  - res_tdata[0]=1: job_result<=res_tdata, go to DONE.
  - Otherwise the timer increments. timer==TIMEOUT-1 with no result -> ERR.
  - A result arriving on the same cycle as the timeout is taken as a result, not an error.
- DONE: job_done=1 for one cycle, then IDLE.
- ERR: job_error=1 for one cycle, then IDLE.
- job_busy=1 in every state except IDLE.
- job_abort in any non-IDLE state: next state is IDLE, counters clear, no done or error pulse.
  - A beat accepted in that same cycle still transfers.
  - Abort has priority over every other transition.
- job_start outside IDLE is ignored, with no queuing.
- Counters are LEN_W bits and never wrap, because comparisons use the latched len-1 and len is at least 1.
- Reset mid-job follows the reset rule above. The accelerator is reset by its own reset at the same time.

Decomposition:
- mMapAdd_package (existing) owns QTree_Bool_t and Pointer_QTree_Nat_t. Add the sched_state_t enum and the RESULT_VALID_BIT=0 constant there.
- One natural sub-module: mmapadd_stream_mux, a 2:1 combinational stream selector with per-source length-driven tlast generation. The FSM, timer and result capture stay in the top.

Test Plan:
- Nominal job: len0=3, len1=2, both sources always valid, m_tready=1. Required: 5 beats in order, m_tlast on beats 3 and 5. res_tdata=32'h0000_0041 two cycles later gives job_result=0x41 and one job_done pulse.
- Backpressure: len0=4, len1=4, m_tready toggling 1010... Required: exactly 8 beats, none duplicated or dropped, source data order preserved, s*_tready tracks m_tready only for the active source.
- Zero length: job_len0=0, job_len1=5. Required: job_error pulse one cycle after accept, no m_tvalid, job_busy high for exactly 1 cycle.
- Timeout: TIMEOUT=16, res_tdata[0] held 0 after feeding. Required: job_error pulse exactly 16 cycles after entry to WAIT_RES, job_result=0, job_done never.
- Abort mid-FEED1: job_abort after 1 of len1=3 beats. Required: IDLE next cycle, no pulses. A following job with len0=1, len1=1 then completes normally with correct tlast.
- Reset and start collisions: areset asserted in WAIT_RES gives all outputs 0 next cycle. job_start during FEED0 is ignored and the lengths are unchanged.
